// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: zero-latency lookup at fetch, training from
// execute-stage resolution, and saturating branch/mispredict statistics.
module branch_predictor #(
   parameter int unsigned AW       = 32,
   parameter int unsigned IDX_BITS = 4,
   parameter int unsigned CW       = 16
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic [AW-1:0] pc_i,
   output logic          predict_taken_o,
   output logic [AW-1:0] predict_target_o,
   input  logic          upd_valid_i,
   input  logic [AW-1:0] upd_pc_i,
   input  logic          upd_taken_i,
   input  logic [AW-1:0] upd_target_i,
   output logic          mispredict_o,
   output logic [CW-1:0] branch_cnt_o,
   output logic [CW-1:0] mispredict_cnt_o
);

   localparam int unsigned TW    = AW - IDX_BITS - 2;
   localparam int unsigned DEPTH = 1 << IDX_BITS;

   // Table storage
   logic          valid_q  [DEPTH];
   logic [TW-1:0] tag_q    [DEPTH];
   logic [AW-1:0] target_q [DEPTH];
   logic [1:0]    ctr_q    [DEPTH];

   logic          mispredict_q, mispredict_d;
   logic [CW-1:0] branch_cnt_q, branch_cnt_d;
   logic [CW-1:0] mispredict_cnt_q, mispredict_cnt_d;

   // Fetch-side lookup signals
   logic [IDX_BITS-1:0] idx_c;
   logic [TW-1:0]       tag_c;
   logic                hit_c;

   // Update-side decode and next entry contents
   logic [IDX_BITS-1:0] u_idx_c;
   logic [TW-1:0]       u_tag_c;
   logic                u_hit_c;
   logic                u_pred_c;
   logic                u_mispred_c;
   logic                ent_we_d;
   logic [TW-1:0]       ent_tag_d;
   logic [AW-1:0]       ent_target_d;
   logic [1:0]          ent_ctr_d;

   // Byte-offset bits never affect prediction
   logic unused_c;
   assign unused_c = ^{pc_i[1:0], upd_pc_i[1:0]};

   // Combinational lookup on the pre-edge table (no bypass from a same-cycle update)
   always_comb begin
      idx_c            = pc_i[IDX_BITS+1:2];
      tag_c            = pc_i[AW-1:IDX_BITS+2];
      hit_c            = valid_q[idx_c] && (tag_q[idx_c] == tag_c);
      predict_taken_o  = hit_c && ctr_q[idx_c][1];
      predict_target_o = predict_taken_o ? target_q[idx_c] : (pc_i + AW'(4));
   end

   // Resolve the update: misprediction check and next entry/counter values
   always_comb begin
      u_idx_c          = upd_pc_i[IDX_BITS+1:2];
      u_tag_c          = upd_pc_i[AW-1:IDX_BITS+2];
      u_hit_c          = valid_q[u_idx_c] && (tag_q[u_idx_c] == u_tag_c);
      u_pred_c         = u_hit_c && ctr_q[u_idx_c][1];
      u_mispred_c      = (u_pred_c != upd_taken_i) ||
                         (u_pred_c && upd_taken_i && (target_q[u_idx_c] != upd_target_i));
      ent_we_d         = 1'b0;
      ent_tag_d        = tag_q[u_idx_c];
      ent_target_d     = target_q[u_idx_c];
      ent_ctr_d        = ctr_q[u_idx_c];
      mispredict_d     = upd_valid_i && u_mispred_c;
      branch_cnt_d     = branch_cnt_q;
      mispredict_cnt_d = mispredict_cnt_q;

      if (upd_valid_i) begin
         if (u_hit_c) begin
            ent_we_d = 1'b1;
            if (upd_taken_i) begin
               ent_ctr_d    = (ctr_q[u_idx_c] == 2'b11) ? 2'b11 : ctr_q[u_idx_c] + 2'd1;
               ent_target_d = upd_target_i;
            end else begin
               ent_ctr_d    = (ctr_q[u_idx_c] == 2'b00) ? 2'b00 : ctr_q[u_idx_c] - 2'd1;
            end
         end else if (upd_taken_i) begin
            ent_we_d     = 1'b1;
            ent_tag_d    = u_tag_c;
            ent_target_d = upd_target_i;
            ent_ctr_d    = 2'b10;
         end

         if (branch_cnt_q != {CW{1'b1}}) begin
            branch_cnt_d = branch_cnt_q + CW'(1);
         end
         if (u_mispred_c && (mispredict_cnt_q != {CW{1'b1}})) begin
            mispredict_cnt_d = mispredict_cnt_q + CW'(1);
         end
      end
   end

   // Table write and statistics registers; reset wins over any update
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= 2'b01;
         end
         mispredict_q     <= 1'b0;
         branch_cnt_q     <= '0;
         mispredict_cnt_q <= '0;
      end else begin
         if (ent_we_d) begin
            valid_q[u_idx_c]  <= 1'b1;
            tag_q[u_idx_c]    <= ent_tag_d;
            target_q[u_idx_c] <= ent_target_d;
            ctr_q[u_idx_c]    <= ent_ctr_d;
         end
         mispredict_q     <= mispredict_d;
         branch_cnt_q     <= branch_cnt_d;
         mispredict_cnt_q <= mispredict_cnt_d;
      end
   end

   assign mispredict_o     = mispredict_q;
   assign branch_cnt_o     = branch_cnt_q;
   assign mispredict_cnt_o = mispredict_cnt_q;

endmodule
